// File: rtl/mult_booth.sv
// Sequential signed multiplier using radix-2 Booth recoding, one step per clock.
// Sits beside the divider and delivers a 2*WIDTH-bit product on HI/LO with a done pulse.
module mult_booth #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mult_in,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             mult_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH:0]   m_reg;
  logic [WIDTH:0]   p_hi;
  logic [WIDTH-1:0] p_lo;
  logic             q;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted_hi;
  logic [WIDTH-1:0] shifted_lo;

  // Booth add/subtract on the W+1-bit partial product, then the arithmetic shift.
  // The extra bit keeps -M representable when A is the most negative value.
  always_comb begin
    sum = p_hi;
    case ({p_lo[0], q})
      2'b01:   sum = p_hi + m_reg;
      2'b10:   sum = p_hi - m_reg;
      default: sum = p_hi;
    endcase
    shifted_hi = {sum[WIDTH], sum[WIDTH:1]};
    shifted_lo = {sum[0], p_lo[WIDTH-1:1]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      m_reg    <= '0;
      p_hi     <= '0;
      p_lo     <= '0;
      q        <= 1'b0;
      count    <= '0;
      HI       <= '0;
      LO       <= '0;
      mult_out <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mult_out <= 1'b0;
          if (mult_in) begin
            m_reg <= {A[WIDTH-1], A};
            p_hi  <= '0;
            p_lo  <= B;
            q     <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          p_hi  <= shifted_hi;
          p_lo  <= shifted_lo;
          q     <= p_lo[0];
          count <= count + 1'b1;
          // HI/LO only ever see the finished product, taken after the last shift.
          if (count == LAST_STEP) begin
            HI       <= shifted_hi[WIDTH-1:0];
            LO       <= shifted_lo;
            mult_out <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          mult_out <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          mult_out <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_booth.sv
// Self-checking bench for mult_booth: directed spec cases plus random operands
// compared against a plain signed-arithmetic product model.
module tb_mult_booth;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic        mult_in;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        mult_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mult_booth #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .A(A), .B(B), .mult_in(mult_in),
    .HI(HI), .LO(LO), .mult_out(mult_out), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] model_product(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Start one multiply, return the edge count to mult_out (-1 on timeout),
  // the product seen with the pulse, and the number of busy cycles.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [63:0] prod, output int busy_cnt);
    @(negedge clock);
    A = a; B = b; mult_in = 1'b1;
    @(posedge clock); #1;
    mult_in = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat = -1;
    prod = '0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock); #1;
      if (busy) busy_cnt++;
      if (mult_out) begin
        lat = i;
        prod = {HI, LO};
        break;
      end
    end
    @(posedge clock); #1;
    if (busy) busy_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b0; A = '0; B = '0; mult_in = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({HI, LO, mult_out, busy} !== 66'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got HI=%h LO=%h mult_out=%b busy=%b, want all 0", HI, LO, mult_out, busy);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [63:0] prod;
    run_mult(32'd3, 32'd5, lat, prod, bc);
    checks++;
    if (lat !== 32) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d edges, want 32", lat);
    end
    checks++;
    if (prod !== 64'h0000_0000_0000_000F) begin
      errors++;
      $display("[TB] FAIL basic_product: got %h, want 000000000000000f", prod);
    end
    checks++;
    if (bc !== 33) begin
      errors++;
      $display("[TB] FAIL basic_busy_cycles: got %0d, want 33", bc);
    end
    checks++;
    if (mult_out !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_return_idle: got mult_out=%b busy=%b, want 0 0", mult_out, busy);
    end
  endtask

  task automatic test_directed();
    logic [31:0] av [5] = '{32'hFFFF_FFF9, 32'd6, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] bv [5] = '{32'd6, 32'hFFFF_FFF9, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    logic [63:0] want [5] = '{64'hFFFF_FFFF_FFFF_FFD6, 64'hFFFF_FFFF_FFFF_FFD6,
                              64'h4000_0000_0000_0000, 64'h3FFF_FFFF_0000_0001,
                              64'hC000_0000_8000_0000};
    int lat, bc;
    logic [63:0] prod;
    for (int i = 0; i < 5; i++) begin
      run_mult(av[i], bv[i], lat, prod, bc);
      checks++;
      if (lat !== 32 || prod !== want[i] || prod !== model_product(av[i], bv[i])) begin
        errors++;
        $display("[TB] FAIL directed_%0d: A=%h B=%h got %h lat=%0d, want %h lat=32",
                 i, av[i], bv[i], prod, lat, want[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [63:0] prod;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) a = 32'($signed($urandom_range(0, 40)) - 20);
      if (i % 4 == 2) b = {1'b1, 31'($urandom)};
      run_mult(a, b, lat, prod, bc);
      checks++;
      if (lat !== 32 || prod !== model_product(a, b)) begin
        errors++;
        $display("[TB] FAIL random_%0d: A=%h B=%h got %h lat=%0d, want %h lat=32",
                 i, a, b, prod, lat, model_product(a, b));
      end
    end
  endtask

  task automatic test_operand_stability();
    int lat;
    logic [63:0] prod;
    @(negedge clock);
    A = 32'd4; B = 32'd4; mult_in = 1'b1;
    @(negedge clock);
    mult_in = 1'b0;
    repeat (10) @(negedge clock);
    A = 32'd100; B = 32'd100; mult_in = 1'b1;
    @(negedge clock);
    mult_in = 1'b0;
    lat = -1;
    prod = '0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (mult_out) begin
        lat = i;
        prod = {HI, LO};
        break;
      end
    end
    checks++;
    if (lat < 0 || prod !== 64'd16) begin
      errors++;
      $display("[TB] FAIL stability_product: got %h (timeout=%0b), want 0000000000000010", prod, lat < 0);
    end
    mult_in = 1'b1;
    @(negedge clock);
    mult_in = 1'b0;
    repeat (5) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || {HI, LO} !== 64'd16) begin
      errors++;
      $display("[TB] FAIL stability_done_pulse_ignored: got busy=%b HI:LO=%h, want 0 and 16", busy, {HI, LO});
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, pulses;
    logic [63:0] prod;
    run_mult(32'd3, 32'd5, lat, prod, bc);
    @(negedge clock);
    A = 32'd2; B = 32'd9; mult_in = 1'b1;
    @(negedge clock);
    mult_in = 1'b0;
    repeat (15) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if ({HI, LO} !== 64'd0 || busy !== 1'b0 || mult_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrun_async_reset: got HI:LO=%h busy=%b mult_out=%b, want 0 0 0", {HI, LO}, busy, mult_out);
    end
    pulses = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (mult_out) pulses++;
    end
    checks++;
    if (pulses !== 0 || {HI, LO} !== 64'd0) begin
      errors++;
      $display("[TB] FAIL midrun_no_completion: got %0d pulses HI:LO=%h, want 0 pulses and 0", pulses, {HI, LO});
    end
    run_mult(32'd2, 32'd9, lat, prod, bc);
    checks++;
    if (lat !== 32 || prod !== model_product(32'd2, 32'd9)) begin
      errors++;
      $display("[TB] FAIL midrun_after_release: got %h lat=%0d, want 0000000000000012 lat=32", prod, lat);
    end
  endtask

  task automatic test_back_to_back();
    int pulse_at [3];
    int n;
    logic [63:0] want;
    want = model_product(32'd10, 32'hFFFF_FFFF);
    n = 0;
    @(negedge clock);
    A = 32'd10; B = 32'hFFFF_FFFF; mult_in = 1'b1;
    for (int i = 0; i < 200 && n < 3; i++) begin
      @(posedge clock); #1;
      if (mult_out) begin
        pulse_at[n] = i;
        checks++;
        if ({HI, LO} !== want) begin
          errors++;
          $display("[TB] FAIL b2b_product_%0d: got %h, want %h", n, {HI, LO}, want);
        end
        n++;
      end
    end
    @(negedge clock);
    mult_in = 1'b0;
    checks++;
    if (n !== 3) begin
      errors++;
      $display("[TB] FAIL b2b_pulse_count: got %0d pulses, want 3", n);
    end else begin
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (pulse_at[k] - pulse_at[k-1] !== 34) begin
          errors++;
          $display("[TB] FAIL b2b_interval_%0d: got %0d cycles, want 34", k, pulse_at[k] - pulse_at[k-1]);
        end
      end
    end
    for (int i = 0; i < 60 && busy; i++) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_random();
    test_operand_stability();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_booth.md
# mult_booth

Sequential signed 32×32 multiplier for the multicycle MIPS datapath, using radix-2 Booth recoding. It sits between the A/B operand registers and the HI/LO registers, in the slot beside the divider. The control unit pulses `mult_in`, and the block samples A and B. One Booth step runs per clock. The 64-bit product is presented on `HI`/`LO` together with a one-cycle `mult_out` pulse, which the control unit uses to assert `high_write`/`low_write`.

## Interface
- `WIDTH`, 32, operand width; the product is 2·`WIDTH` bits, split into `HI` (upper) and `LO` (lower).
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it (0) clears all state immediately.
- `A`  in  WIDTH  multiplicand, two's complement; sampled only on the start edge.
- `B`  in  WIDTH  multiplier, two's complement; sampled only on the start edge.
- `mult_in`  in  1  start request; honoured only in IDLE.
- `HI`  out  WIDTH  product bits [2W-1:W]; registered.
- `LO`  out  WIDTH  product bits [W-1:0]; registered.
- `mult_out`  out  1  done; high for exactly one cycle when `HI`/`LO` carry a new product.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- **States:**
  - IDLE: waits for `mult_in`.
  - RUN: performs one Booth step per cycle.
  - DONE: holds for one cycle, drives `mult_out`=1, then returns to IDLE.
- **IDLE → RUN** on an edge with `mult_in`=1:
  - M ← sign-extend(A) to W+1 bits.
  - P_hi ← 0 (W+1 bits).
  - P_lo ← B.
  - q ← 0.
  - count ← 0.
- **RUN step** (each edge):
  - Examine {P_lo[0], q}.
  - 01: P_hi += M.
  - 10: P_hi −= M.
  - 00 and 11: no change.
  - Then arithmetic-shift {P_hi, P_lo, q} right by 1; P_hi's sign bit is replicated.
  - count += 1.
  - On the step where count = W−1: HI ← P_hi[W-1:0] and LO ← P_lo, taken after the shift; state → DONE.
- **Width rule:** P_hi is W+1 bits, so negating M = −2^(W−1) cannot overflow. All arithmetic is mod 2^(W+1) on P_hi.
- **Result:** the exact signed 2W-bit product, equal to (signed A) × (signed B), for every operand pair including the extremes.
- **HI/LO hold:** `HI`/`LO` change only on the completion edge. They hold the last product indefinitely, and no intermediate values are ever visible.
- **Operand changes:** changes on `A`/`B` after the start edge have no effect.
- **`mult_in` while busy:** ignored in RUN and DONE; it is not queued. A start is accepted only on an edge where the state is already IDLE.
- **Reset:** all outputs and state go to 0 / IDLE (`HI`=0, `LO`=0, `mult_out`=0, `busy`=0). Reset in the middle of an operation aborts it, and the partial product never reaches `HI`/`LO`.

## Timing
- **Latency:**
  - Edge E0 samples `mult_in`.
  - Edges E1…E32 perform steps 0…31.
  - E32 loads `HI`/`LO` and enters DONE.
  - `mult_out`=1 in the cycle after E32, i.e., 32 edges after the start edge, which is the same cycle the new `HI`/`LO` first appear.
- **DONE → IDLE:** E33 returns to IDLE and `mult_out` falls. The earliest next start is accepted on E34.
- **`busy`:** high from the cycle after E0 through the DONE cycle (33 cycles total).
- **Throughput:** one multiply every 34 cycles under back-to-back starts.
- **Combinational paths:** `mult_out`, `busy`, `HI` and `LO` are decoded purely from registers, with no combinational path from any input.

## Test plan
- **Basic product:** after reset, A=3, B=5, pulse `mult_in` → `mult_out` high exactly 32 edges later with HI=0x00000000, LO=0x0000000F; `busy` high for 33 cycles.
- **Mixed signs:** A=0xFFFFFFF9 (−7), B=6 → HI=0xFFFFFFFF, LO=0xFFFFFFD6. Then A=6, B=0xFFFFFFF9 → same result.
- **Extremes:**
  - A=B=0x80000000 → HI=0x40000000, LO=0x00000000.
  - A=B=0x7FFFFFFF → HI=0x3FFFFFFF, LO=0x00000001.
  - A=0x80000000, B=0x7FFFFFFF → HI=0xC0000000, LO=0x80000000.
- **Operand stability:** start A=4, B=4, then change A/B to 100 and pulse `mult_in` at step 10 and in the DONE cycle → both pulses ignored; result HI=0, LO=16; HI/LO unchanged until the next accepted start.
- **Reset mid-run:** after a completed 3×5, start A=2, B=9 and drop `reset` at step 15 → HI=LO=0 and `busy`=0 immediately (asynchronous), with no `mult_out`. After release, A=2, B=9 → LO=18.
- **Back-to-back:** hold `mult_in`=1 continuously with fixed A=10, B=−1 → `mult_out` pulses every 34 cycles, each with HI=0xFFFFFFFF, LO=0xFFFFFFF6.
